mp_dist_ram: RTL and testbench
==============================

// Module: mp_dist_ram
// PURPOSE
//   Parametrised multi-read-port distributed RAM: one synchronous write port with byte enables,
//   NUM_READ_PORTS asynchronous (zero-latency) read ports, built-in clear sequencer.
//   Successor to the single-read-port LUT RAM; used for register files (2R1W), multi-issue tables.
//   Clear sequencer zeroes every entry after reset or on request; no initial-block dependence.
// PARAMETERS
//   ADDR_WIDTH      5   address bits; depth = 2**ADDR_WIDTH
//   DATA_WIDTH      32  word width; must be a multiple of BYTE_WIDTH (elaboration $error otherwise)
//   BYTE_WIDTH      8   bits per write-enable lane; NumBytes = DATA_WIDTH/BYTE_WIDTH
//   NUM_READ_PORTS  2   independent async read ports, >= 1
// PORTS
//   i_clk              in   1                          clock
//   i_rst              in   1                          reset, asynchronous, active-high
//   i_clear            in   1                          request full-array clear (pulse)
//   i_write_enable     in   1                          write strobe
//   i_write_byte_en    in   NumBytes                   per-lane write mask
//   i_write_address    in   ADDR_WIDTH                 write address
//   i_write_data       in   DATA_WIDTH                 write data
//   i_read_address     in   NUM_READ_PORTS x ADDR_WIDTH  read addresses (packed array)
//   o_read_data        out  NUM_READ_PORTS x DATA_WIDTH  read data (combinational)
//   o_ready            out  1                          array valid, accepting writes
// BEHAVIOUR
//   - States: CLEARING, READY. Reset (async) -> CLEARING, clear_idx = 0, o_ready = 0.
//   - CLEARING: each cycle writes '0 to ram[clear_idx], clear_idx++. When clear_idx == 2**ADDR_WIDTH-1
//     is written, next state READY; o_ready = 1 on the following cycle. Clear takes exactly
//     2**ADDR_WIDTH cycles after reset release.
//   - CLEARING: user writes dropped (no backpressure; caller must gate on o_ready);
//     all o_read_data forced to '0 regardless of array contents.
//   - READY: i_clear=1 -> CLEARING, clear_idx=0, o_ready falls next cycle; a write in the same cycle
//     as i_clear IS committed (then overwritten by the sweep). i_clear while CLEARING: ignored.
//   - Reset mid-clear: restart from clear_idx = 0. Array contents are not reset asynchronously
//     (LUT RAM); only FSM/counter are.
//   - Write (READY): on posedge, for each lane b with i_write_byte_en[b]=1,
//     ram[addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= data lane; other lanes unchanged. byte_en='0 is a no-op.
//   - Read: o_read_data[p] = ram[i_read_address[p]] combinationally; ports fully independent,
//     identical addresses on several ports legal.
//   - Read/write same address, same cycle: read returns OLD word (see CONFIGURATION for bypass).
//   - Outputs at reset: o_ready=0, o_read_data='0.
// CONFIGURATION
//   Macro MP_DIST_RAM_WRITE_BYPASS_EN:
//   - defined: in READY, if i_write_enable and i_read_address[p]==i_write_address, o_read_data[p]
//     returns merged word (enabled lanes from i_write_data, others from array) in the same cycle.
//   - undefined: no bypass; read returns pre-write contents; no write->read combinational path.
// STRUCTURE
//   - mp_dist_ram_pkg: state enum typedef (CLEARING, READY), helper function num_bytes(dw, bw).
//   - Sub-module mp_dist_ram_clear_ctrl: FSM + clear_idx counter; outputs clear write strobe,
//     clear address, o_ready. Top muxes clear vs user write into a single array write port.
//   - Array: one logic [DATA_WIDTH-1:0] ram[2**ADDR_WIDTH], single always_ff write, generate loop
//     for read ports.
// TESTING
//   1. Reset release, defaults -> o_ready low exactly 32 cycles, high on cycle 33; all reads 0.
//   2. Write 0xDEADBEEF @5 byte_en 4'hF, then byte_en 4'b0010 data 0x0000AA00 -> read @5 = 0xDEADAABE... no: = 0xDEADAAEF.
//   3. Port0 @3, port1 @3, port0 @7 after writes 0x11/0x77 -> simultaneous reads 0x11,0x11 then 0x77.
//   4. Same-cycle write 0x1234 @9 and read @9 (old 0x5) -> 0x5 without macro, 0x1234 with macro.
//   5. i_clear in READY after filling all entries -> o_ready low 32 cycles, then every address reads 0.
//   6. i_rst asserted at clear_idx=10 -> o_ready stays 0, sweep restarts at 0, full 32 cycles.

Source files
------------

// File: rtl/mp_dist_ram_pkg.sv
// Shared types and helpers for the multi-read-port distributed RAM.
// Optional same-cycle write bypass is selected with MP_DIST_RAM_WRITE_BYPASS_EN.
package mp_dist_ram_pkg;

  typedef enum logic [0:0] {
    CLEARING = 1'b0,
    READY    = 1'b1
  } ram_state_e;

  function automatic int num_bytes(input int dw, input int bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/mp_dist_ram_if.sv
// Bus bundle for mp_dist_ram: one byte-masked write port, N async read ports, ready flag.
// Handshake: o_ready is the only flow control; writes presented while it is low are discarded.
interface mp_dist_ram_if
  import mp_dist_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int NUM_READ_PORTS = 2
);
  localparam int NumBytes = num_bytes(DATA_WIDTH, BYTE_WIDTH);

  logic                                           i_clear;
  logic                                           i_write_enable;
  logic [NumBytes-1:0]                            i_write_byte_en;
  logic [ADDR_WIDTH-1:0]                          i_write_address;
  logic [DATA_WIDTH-1:0]                          i_write_data;
  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]      i_read_address;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]      o_read_data;
  logic                                           o_ready;

  modport master (
    output i_clear, i_write_enable, i_write_byte_en, i_write_address, i_write_data,
    output i_read_address,
    input  o_read_data, o_ready
  );

  modport slave (
    input  i_clear, i_write_enable, i_write_byte_en, i_write_address, i_write_data,
    input  i_read_address,
    output o_read_data, o_ready
  );

endinterface

// File: rtl/mp_dist_ram_clear_ctrl.sv
// Clear sequencer: sweeps every address with zero after reset or on request, then reports ready.
module mp_dist_ram_clear_ctrl
  import mp_dist_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  output logic                  o_clear_we,
  output logic [ADDR_WIDTH-1:0] o_clear_addr,
  output logic                  o_ready,
  output logic [0:0]            o_state
);
  localparam logic [0:0] ST_CLEARING = CLEARING;
  localparam logic [0:0] ST_READY    = READY;

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] idx_q;

  // A clear request while already sweeping is ignored; the sweep never restarts except on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_CLEARING;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEARING: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) state_q <= ST_READY;
        end
        ST_READY: begin
          if (i_clear) begin
            state_q <= ST_CLEARING;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_CLEARING;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign o_clear_we   = (state_q == ST_CLEARING);
  assign o_clear_addr = idx_q;
  assign o_ready      = (state_q == ST_READY);
  assign o_state      = state_q;

endmodule

// File: rtl/mp_dist_ram.sv
// Multi-read-port LUT RAM with byte-masked write and built-in clear sweep.
// Define MP_DIST_RAM_WRITE_BYPASS_EN to forward a same-cycle write onto matching read ports.
module mp_dist_ram
  import mp_dist_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mp_dist_ram_if.slave bus,
  output logic [0:0]  o_state
);
  localparam int NumBytes = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int Depth    = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("mp_dist_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (NUM_READ_PORTS < 1) begin : g_bad_ports
    $error("mp_dist_ram: NUM_READ_PORTS must be at least 1");
  end

  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  ready;
  logic                  user_we;

  mp_dist_ram_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_ctrl (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (bus.i_clear),
    .o_clear_we   (clear_we),
    .o_clear_addr (clear_addr),
    .o_ready      (ready),
    .o_state      (o_state)
  );

  assign user_we     = ready & bus.i_write_enable;
  assign bus.o_ready = ready;

  // Contents are deliberately left out of reset so the array maps onto LUT RAM.
  logic [DATA_WIDTH-1:0] ram [Depth];

  always_ff @(posedge i_clk) begin
    if (clear_we) begin
      ram[clear_addr] <= '0;
    end else if (user_we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (bus.i_write_byte_en[b])
          ram[bus.i_write_address][b*BYTE_WIDTH +: BYTE_WIDTH] <=
            bus.i_write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] word;
`ifdef MP_DIST_RAM_WRITE_BYPASS_EN
    always_comb begin
      word = ram[bus.i_read_address[p]];
      if (user_we && (bus.i_read_address[p] == bus.i_write_address)) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (bus.i_write_byte_en[b])
            word[b*BYTE_WIDTH +: BYTE_WIDTH] = bus.i_write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
`else
    assign word = ram[bus.i_read_address[p]];
`endif
    // The array is not trusted until the sweep finishes, so reads are masked meanwhile.
    assign rd_data[p] = ready ? word : '0;
  end

  assign bus.o_read_data = rd_data;

endmodule

// File: tb/tb_mp_dist_ram.sv
// Directed bench for mp_dist_ram (default 32x32, 2 read ports, 4 byte lanes).
module tb_mp_dist_ram;

  logic       i_clk;
  logic       i_rst;
  logic [0:0] o_state;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  mp_dist_ram_if #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_READ_PORTS(2)
  ) bus ();

  mp_dist_ram #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8), .NUM_READ_PORTS(2)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .bus     (bus),
    .o_state (o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge i_clk);
    bus.i_write_enable  = 1'b1;
    bus.i_write_address = a;
    bus.i_write_data    = d;
    bus.i_write_byte_en = be;
    @(posedge i_clk);
    #1;
    bus.i_write_enable  = 1'b0;
    bus.i_write_byte_en = '0;
  endtask

  task automatic rd(input string tag, input int port, input logic [4:0] a, input logic [31:0] exp);
    bus.i_read_address[port] = a;
    #1;
    check(tag, bus.o_read_data[port], exp);
  endtask

  task automatic pulse_clear();
    @(negedge i_clk);
    bus.i_clear = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_clear = 1'b0;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (!bus.o_ready && edges < 100) begin
      @(posedge i_clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    bus.i_clear         = 1'b0;
    bus.i_write_enable  = 1'b0;
    bus.i_write_byte_en = '0;
    bus.i_write_address = '0;
    bus.i_write_data    = '0;
    bus.i_read_address  = '0;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;

    // 1: reset state, then exactly 32 sweep cycles
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    rd("rst_rd0", 0, 5'd4, 32'd0);
    rd("rst_rd1", 1, 5'd17, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    wait_ready(n);
    check("init_clear_len", n, 32'd32);
    check("init_ready", {31'd0, bus.o_ready}, 32'd1);
    rd("init_rd0", 0, 5'd0, 32'd0);
    rd("init_rd1", 1, 5'd31, 32'd0);

    // 2: byte-lane merge and masked no-op
    do_write(5'd5, 32'hDEADBEEF, 4'hF);
    rd("full_write", 0, 5'd5, 32'hDEADBEEF);
    do_write(5'd5, 32'h0000AA00, 4'b0010);
    rd("lane1_merge", 0, 5'd5, 32'hDEADAAEF);
    do_write(5'd5, 32'hFFFFFFFF, 4'b0000);
    rd("be_zero_noop", 1, 5'd5, 32'hDEADAAEF);

    // 3: independent ports, shared address
    do_write(5'd3, 32'h11, 4'hF);
    do_write(5'd7, 32'h77, 4'hF);
    bus.i_read_address[0] = 5'd3;
    bus.i_read_address[1] = 5'd3;
    #1;
    check("shared_p0", bus.o_read_data[0], 32'h11);
    check("shared_p1", bus.o_read_data[1], 32'h11);
    bus.i_read_address[0] = 5'd7;
    #1;
    check("split_p0", bus.o_read_data[0], 32'h77);
    check("split_p1", bus.o_read_data[1], 32'h11);

    // 4: same-cycle write and read on one address
    do_write(5'd9, 32'h5, 4'hF);
    @(negedge i_clk);
    bus.i_write_enable    = 1'b1;
    bus.i_write_address   = 5'd9;
    bus.i_write_data      = 32'h1234;
    bus.i_write_byte_en   = 4'hF;
    bus.i_read_address[1] = 5'd9;
    #1;
`ifdef MP_DIST_RAM_WRITE_BYPASS_EN
    check("rw_same_cycle", bus.o_read_data[1], 32'h1234);
`else
    check("rw_same_cycle", bus.o_read_data[1], 32'h5);
`endif
    @(posedge i_clk);
    #1;
    bus.i_write_enable  = 1'b0;
    bus.i_write_byte_en = '0;
    check("rw_after_edge", bus.o_read_data[1], 32'h1234);

    // 5: fill, clear in READY, ignored re-clear, dropped write during sweep
    for (int i = 0; i < 32; i++) do_write(i[4:0], 32'hA5000000 | i, 4'hF);
    rd("fill_31", 0, 5'd31, 32'hA500001F);
    rd("fill_9", 1, 5'd9, 32'hA5000009);
    pulse_clear();
    check("clear_ready_fall", {31'd0, bus.o_ready}, 32'd0);
    n = 0;
    while (!bus.o_ready && n < 100) begin
      @(negedge i_clk);
      if (n == 10) bus.i_clear = 1'b1;
      if (n == 20) begin
        bus.i_write_enable  = 1'b1;
        bus.i_write_address = 5'd0;
        bus.i_write_data    = 32'hCAFE;
        bus.i_write_byte_en = 4'hF;
      end
      @(posedge i_clk);
      #1;
      bus.i_clear         = 1'b0;
      bus.i_write_enable  = 1'b0;
      bus.i_write_byte_en = '0;
      n++;
      if (n == 5) check("clearing_rd_masked", bus.o_read_data[0], 32'd0);
    end
    check("req_clear_len", n, 32'd32);
    for (int i = 0; i < 32; i++) begin
      bus.i_read_address[i % 2] = i[4:0];
      #1;
      check($sformatf("swept_%0d", i), bus.o_read_data[i % 2], 32'd0);
    end

    // 6: reset mid-sweep restarts from address 0
    do_write(5'd2, 32'hAB, 4'hF);
    rd("pre_rst_fill", 0, 5'd2, 32'hAB);
    pulse_clear();
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.o_ready}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    wait_ready(n);
    check("midrst_clear_len", n, 32'd32);
    rd("midrst_swept", 0, 5'd2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
